// File: rtl/fpu_pkg.sv
// Shared opcodes, encodings, FSM states and helpers for the FPU issue controller.
package fpu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned RS_W   = 5;
  localparam int unsigned FLAG_W = 5;

  localparam logic [F7_W-1:0] F7_FADD_S   = 7'b0000000;
  localparam logic [F7_W-1:0] F7_FADD_D   = 7'b0000001;
  localparam logic [F7_W-1:0] F7_FSUB_S   = 7'b0000100;
  localparam logic [F7_W-1:0] F7_FSUB_D   = 7'b0000101;
  localparam logic [F7_W-1:0] F7_FMUL_S   = 7'b0001000;
  localparam logic [F7_W-1:0] F7_FMUL_D   = 7'b0001001;
  localparam logic [F7_W-1:0] F7_FDIV_S   = 7'b0001100;
  localparam logic [F7_W-1:0] F7_FDIV_D   = 7'b0001101;
  localparam logic [F7_W-1:0] F7_FCMP_S   = 7'b1010000;
  localparam logic [F7_W-1:0] F7_FCMP_D   = 7'b1010001;
  localparam logic [F7_W-1:0] F7_FCVT_S_D = 7'b0100000;
  localparam logic [F7_W-1:0] F7_FCVT_D_S = 7'b0100001;
  localparam logic [F7_W-1:0] F7_FCVT_W_S = 7'b1100000;
  localparam logic [F7_W-1:0] F7_FCVT_W_D = 7'b1100001;
  localparam logic [F7_W-1:0] F7_FCVT_S_W = 7'b1101000;
  localparam logic [F7_W-1:0] F7_FCVT_D_W = 7'b1101001;

  localparam logic [F3_W-1:0] RM_DYN = 3'b111;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

  localparam logic [31:0]     QNAN_S = 32'h7FC0_0000;
  localparam logic [XLEN-1:0] QNAN_D = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {FMT_FP32, FMT_FP64, FMT_INT32, FMT_UINT32} fmt_e;
  typedef enum logic [1:0] {RES_RAW, RES_BOX, RES_SEXT} res_sel_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

  typedef struct packed {
    logic [F7_W-1:0] func7;
    logic [F3_W-1:0] func3;
    logic [RS_W-1:0] rs2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
  } fpu_req_t;

  function automatic logic [XLEN-1:0] nan_unbox(input logic [XLEN-1:0] x);
    return (x[63:32] == 32'hFFFF_FFFF) ? x : {32'h0000_0000, QNAN_S};
  endfunction

  function automatic logic [XLEN-1:0] fmt_result(input res_sel_e sel, input logic [XLEN-1:0] r);
    case (sel)
      RES_BOX:  return {32'hFFFF_FFFF, r[31:0]};
      RES_SEXT: return {{32{r[31]}}, r[31:0]};
      default:  return r;
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_decode.sv
// Combinational decode: legality, rounding-mode resolution, NaN-unboxing and writeback format.
module fpu_issue_decode
  import fpu_pkg::*;
(
  input  logic [F7_W-1:0] func7_i,
  input  logic [F3_W-1:0] func3_i,
  input  logic [RS_W-1:0] rs2_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [F3_W-1:0] frm_i,
  output logic            legal_c_o,
  output fpu_req_t        req_c_o,
  output logic            is_int_c_o,
  output res_sel_e        res_sel_c_o
);

  logic is_arith, is_cmp, is_cvt, is_cvt_w, rm_ok;
  fmt_e src_fmt;

  always_comb begin
    is_arith = func7_i inside {F7_FADD_S, F7_FADD_D, F7_FSUB_S, F7_FSUB_D,
                               F7_FMUL_S, F7_FMUL_D, F7_FDIV_S, F7_FDIV_D};
    is_cmp   = func7_i inside {F7_FCMP_S, F7_FCMP_D};
    is_cvt   = func7_i inside {F7_FCVT_S_D, F7_FCVT_D_S, F7_FCVT_W_S,
                               F7_FCVT_W_D, F7_FCVT_S_W, F7_FCVT_D_W};
    is_cvt_w = func7_i inside {F7_FCVT_W_S, F7_FCVT_W_D};

    req_c_o.func7 = func7_i;
    req_c_o.func3 = func3_i;
    req_c_o.rs2   = rs2_i;
    rm_ok         = 1'b1;
    // Compares carry a predicate in func3, everything else a rounding mode
    if (is_cmp) begin
      rm_ok = func3_i inside {3'b000, 3'b001, 3'b010};
    end else if (func3_i == RM_DYN) begin
      req_c_o.func3 = frm_i;
      rm_ok         = !(frm_i inside {3'b101, 3'b110, 3'b111});
    end else begin
      rm_ok = !(func3_i inside {3'b101, 3'b110});
    end
    legal_c_o = (is_arith || is_cmp || is_cvt) && rm_ok;

    if (func7_i inside {F7_FCVT_S_W, F7_FCVT_D_W})
      src_fmt = rs2_i[0] ? FMT_UINT32 : FMT_INT32;
    else if (!func7_i[0] && (func7_i != F7_FCVT_S_D))
      src_fmt = FMT_FP32;
    else
      src_fmt = FMT_FP64;

    // Converts only read operand A, so B is left untouched for them
    req_c_o.op_a = (src_fmt == FMT_FP32) ? nan_unbox(op_a_i) : op_a_i;
    req_c_o.op_b = ((src_fmt == FMT_FP32) && !is_cvt) ? nan_unbox(op_b_i) : op_b_i;

    is_int_c_o = is_cmp || is_cvt_w;
    if (is_cmp)        res_sel_c_o = RES_RAW;
    else if (is_cvt_w) res_sel_c_o = RES_SEXT;
    else if (func7_i[0]) res_sel_c_o = RES_RAW;
    else               res_sel_c_o = RES_BOX;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one F/D instruction at a time to a fixed-latency FPU and returns a formatted writeback.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [F7_W-1:0]   req_func7,
  input  logic [F3_W-1:0]   req_func3,
  input  logic [RS_W-1:0]   req_rs2,
  input  logic [4:0]        req_rd,
  input  logic [XLEN-1:0]   req_op_a,
  input  logic [XLEN-1:0]   req_op_b,
  input  logic              flush,
  input  logic [F3_W-1:0]   frm,
  output logic [F7_W-1:0]   fpu_func7,
  output logic [F3_W-1:0]   fpu_func3,
  output logic [RS_W-1:0]   fpu_rs2,
  output logic [XLEN-1:0]   fpu_operand_a,
  output logic [XLEN-1:0]   fpu_operand_b,
  input  logic [XLEN-1:0]   fpu_result,
  input  logic [FLAG_W-1:0] fpu_flags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_is_int,
  output logic              wb_illegal,
  output logic [FLAG_W-1:0] fflags,
  input  logic              fflags_wr,
  input  logic [FLAG_W-1:0] fflags_wdata,
  input  logic              fflags_clr
);

  localparam int unsigned      CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  fpu_req_t          fpu_q, fpu_d;
  res_sel_e          res_sel_q, res_sel_d;
  logic              req_ready_q, req_ready_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_illegal_q, wb_illegal_d;
  logic              wb_is_int_q, wb_is_int_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] fflags_q, fflags_d;
  logic              acc_c;

  logic              dec_legal_c;
  fpu_req_t          dec_req_c;
  logic              dec_is_int_c;
  res_sel_e          dec_res_sel_c;

  fpu_issue_decode u_decode (
    .func7_i     (req_func7),
    .func3_i     (req_func3),
    .rs2_i       (req_rs2),
    .op_a_i      (req_op_a),
    .op_b_i      (req_op_b),
    .frm_i       (frm),
    .legal_c_o   (dec_legal_c),
    .req_c_o     (dec_req_c),
    .is_int_c_o  (dec_is_int_c),
    .res_sel_c_o (dec_res_sel_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fpu_d        = fpu_q;
    res_sel_d    = res_sel_q;
    wb_valid_d   = wb_valid_q;
    wb_illegal_d = wb_illegal_q;
    wb_is_int_d  = wb_is_int_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    flags_d      = flags_q;
    acc_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          wb_rd_d = req_rd;
          if (dec_legal_c) begin
            fpu_d        = dec_req_c;
            res_sel_d    = dec_res_sel_c;
            wb_is_int_d  = dec_is_int_c;
            wb_illegal_d = 1'b0;
            cnt_d        = '0;
            state_d      = ST_EXEC;
          end else begin
            wb_illegal_d = 1'b1;
            wb_is_int_d  = 1'b0;
            wb_data_d    = '0;
            flags_d      = '0;
            wb_valid_d   = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_data_d  = fmt_result(res_sel_q, fpu_result);
          flags_d    = fpu_flags;
          wb_valid_d = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (flush) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (wb_ready) begin
          wb_valid_d = 1'b0;
          acc_c      = !wb_illegal_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear beats write; a retiring op's flags are ORed on top of either
    if (fflags_clr)     fflags_d = '0;
    else if (fflags_wr) fflags_d = fflags_wdata;
    else                fflags_d = fflags_q;
    if (acc_c) fflags_d = fflags_d | flags_q;

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fpu_q        <= '0;
      res_sel_q    <= RES_RAW;
      req_ready_q  <= 1'b1;
      wb_valid_q   <= 1'b0;
      wb_illegal_q <= 1'b0;
      wb_is_int_q  <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      flags_q      <= '0;
      fflags_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fpu_q        <= fpu_d;
      res_sel_q    <= res_sel_d;
      req_ready_q  <= req_ready_d;
      wb_valid_q   <= wb_valid_d;
      wb_illegal_q <= wb_illegal_d;
      wb_is_int_q  <= wb_is_int_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      flags_q      <= flags_d;
      fflags_q     <= fflags_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign fpu_func7     = fpu_q.func7;
  assign fpu_func3     = fpu_q.func3;
  assign fpu_rs2       = fpu_q.rs2;
  assign fpu_operand_a = fpu_q.op_a;
  assign fpu_operand_b = fpu_q.op_b;
  assign wb_valid      = wb_valid_q;
  assign wb_illegal    = wb_illegal_q;
  assign wb_is_int     = wb_is_int_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign fflags        = fflags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl; the FPU is modelled by bench-driven result/flag values.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int unsigned LAT = 1;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [6:0]  req_func7;
  logic [2:0]  req_func3;
  logic [4:0]  req_rs2, req_rd;
  logic [63:0] req_op_a, req_op_b;
  logic        flush;
  logic [2:0]  frm;
  logic [6:0]  fpu_func7;
  logic [2:0]  fpu_func3;
  logic [4:0]  fpu_rs2;
  logic [63:0] fpu_operand_a, fpu_operand_b, fpu_result;
  logic [4:0]  fpu_flags;
  logic        wb_valid, wb_ready, wb_is_int, wb_illegal;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [4:0]  fflags, fflags_wdata;
  logic        fflags_wr, fflags_clr;

  fpu_issue_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func7(req_func7), .req_func3(req_func3), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .flush(flush), .frm(frm),
    .fpu_func7(fpu_func7), .fpu_func3(fpu_func3), .fpu_rs2(fpu_rs2),
    .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_is_int(wb_is_int), .wb_illegal(wb_illegal),
    .fflags(fflags), .fflags_wr(fflags_wr), .fflags_wdata(fflags_wdata), .fflags_clr(fflags_clr)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        is_int;
    logic        illegal;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  exp_ff = '0;
  logic [6:0]  last_f7 = '0;
  logic [2:0]  last_f3 = '0;
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one request, wait for its writeback, compare against the scoreboard head
  task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input logic [4:0] flg, input logic ill,
                       input logic [2:0] ef3, input logic [63:0] ea, input logic [63:0] eb,
                       input logic [63:0] ed, input logic eint, input int hold);
    exp_t e;
    int   cyc;
    if (!ill) begin
      last_f7 = f7; last_f3 = ef3; last_a = ea; last_b = eb;
    end
    e.rd = rd; e.data = ill ? 64'h0 : ed; e.is_int = ill ? 1'b0 : eint; e.illegal = ill;
    e.f7 = last_f7; e.f3 = last_f3; e.a = last_a; e.b = last_b;
    sb.push_back(e);
    check("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_func7 = f7; req_func3 = f3; req_rs2 = rs2; req_rd = rd;
    req_op_a = a; req_op_b = b; fpu_result = res; fpu_flags = flg;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!wb_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), ill ? 64'(1) : 64'(LAT + 1));
    e = sb.pop_front();
    if (!wb_valid) return;
    check("wb_data", wb_data, e.data);
    check("wb_rd", 64'(wb_rd), 64'(e.rd));
    check("wb_is_int", 64'(wb_is_int), 64'(e.is_int));
    check("wb_illegal", 64'(wb_illegal), 64'(e.illegal));
    check("fpu_func7", 64'(fpu_func7), 64'(e.f7));
    check("fpu_func3", 64'(fpu_func3), 64'(e.f3));
    check("fpu_op_a", fpu_operand_a, e.a);
    check("fpu_op_b", fpu_operand_b, e.b);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(wb_valid), 64'(1));
      check("hold_data", wb_data, e.data);
      check("hold_ready", 64'(req_ready), 64'(0));
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    if (!ill) exp_ff = exp_ff | flg;
    check("wb_valid_drop", 64'(wb_valid), 64'(0));
    check("req_ready_back", 64'(req_ready), 64'(1));
    check("fflags", 64'(fflags), 64'(exp_ff));
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_func7 = '0; req_func3 = '0; req_rs2 = '0; req_rd = '0;
    req_op_a = '0; req_op_b = '0; flush = 0; frm = '0; fpu_result = '0; fpu_flags = '0;
    wb_ready = 0; fflags_wr = 0; fflags_wdata = '0; fflags_clr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_wb_illegal", 64'(wb_illegal), 64'(0));
    check("rst_wb_is_int", 64'(wb_is_int), 64'(0));
    check("rst_wb_data", wb_data, 64'h0);
    check("rst_wb_rd", 64'(wb_rd), 64'(0));
    check("rst_fpu_a", fpu_operand_a, 64'h0);
    check("rst_fpu_f7", 64'(fpu_func7), 64'(0));
    check("rst_fflags", 64'(fflags), 64'(0));

    // FADD.S, dynamic rounding from frm=000, boxed operands, result gets NaN-boxed
    frm = 3'b000;
    issue(7'b0000000, 3'b111, 5'd0, 5'd1, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_40000000,
          64'hDEADBEEF_40400000, 5'h00, 1'b0, 3'b000,
          64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_40000000, 64'hFFFFFFFF_40400000, 1'b0, 0);
    // FMUL.S with an improperly boxed operand A
    issue(7'b0001000, 3'b000, 5'd0, 5'd2, 64'h00000000_3F800000, 64'hFFFFFFFF_3F800000,
          64'h00000000_7FC00000, 5'h00, 1'b0, 3'b000,
          64'h00000000_7FC00000, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_7FC00000, 1'b0, 0);
    // FCVT.W.S -> integer regfile, sign-extended
    issue(7'b1100000, 3'b001, 5'd0, 5'd3, 64'hFFFFFFFF_BF800000, 64'h12345678_00000000,
          64'h00000000_FFFFFFFF, 5'h00, 1'b0, 3'b001,
          64'hFFFFFFFF_BF800000, 64'h12345678_00000000, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 0);
    // FDIV.D by zero raises DZ
    issue(7'b0001101, 3'b000, 5'd0, 5'd4, 64'h3FF0000000000000, 64'h0,
          64'h7FF0000000000000, 5'b01000, 1'b0, 3'b000,
          64'h3FF0000000000000, 64'h0, 64'h7FF0000000000000, 1'b0, 0);
    check("fflags_dz", 64'(fflags[FFLAG_DZ]), 64'(1));
    // Exact FADD.D leaves accrued flags alone
    issue(7'b0000001, 3'b000, 5'd0, 5'd5, 64'h3FF0000000000000, 64'h3FF0000000000000,
          64'h4000000000000000, 5'h00, 1'b0, 3'b000,
          64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 0);
    fflags_clr = 1'b1; @(posedge clk); #1; fflags_clr = 1'b0; exp_ff = '0;
    check("fflags_clr", 64'(fflags), 64'(0));

    // FCMP.S: predicate passed through, unboxed B, raw integer result
    issue(7'b1010000, 3'b010, 5'd0, 5'd6, 64'hFFFFFFFF_3F800000, 64'h12345678_3F800000,
          64'hAAAA0000_00000001, 5'h00, 1'b0, 3'b010,
          64'hFFFFFFFF_3F800000, 64'h00000000_7FC00000, 64'hAAAA0000_00000001, 1'b1, 0);
    // FSUB.D with dynamic frm=001, writeback stalled for 5 cycles
    frm = 3'b001;
    issue(7'b0000101, 3'b111, 5'd0, 5'd7, 64'h4008000000000000, 64'h3FF0000000000000,
          64'h4000000000000000, 5'b00001, 1'b0, 3'b001,
          64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 5);

    // Flush during EXEC: operation dropped, its flags never accrue
    req_valid = 1'b1; req_func7 = 7'b0001001; req_func3 = 3'b000; req_rd = 5'd8;
    req_op_a = 64'h1; req_op_b = 64'h2; fpu_result = 64'h55; fpu_flags = 5'b11111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    last_f7 = 7'b0001001; last_f3 = 3'b000; last_a = 64'h1; last_b = 64'h2;
    check("exec_ready", 64'(req_ready), 64'(0));
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    check("flush_valid", 64'(wb_valid), 64'(0));
    check("flush_ready", 64'(req_ready), 64'(1));
    repeat (3) @(posedge clk); #1;
    check("flush_no_wb", 64'(wb_valid), 64'(0));
    check("flush_fflags", 64'(fflags), 64'(exp_ff));

    // Illegal: dynamic rounding resolving to reserved frm
    frm = 3'b101;
    issue(7'b0000001, 3'b111, 5'd0, 5'd9, 64'h1, 64'h2, 64'h99, 5'b11111, 1'b1,
          3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 0);
    frm = 3'b000;
    // Illegal opcode
    issue(7'b0111111, 3'b000, 5'd0, 5'd10, 64'h3, 64'h4, 64'h99, 5'b11111, 1'b1,
          3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 0);
    // Illegal compare predicate and reserved static rounding mode
    issue(7'b1010001, 3'b011, 5'd0, 5'd11, 64'h5, 64'h6, 64'h99, 5'b11111, 1'b1,
          3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 0);
    issue(7'b0000000, 3'b101, 5'd0, 5'd12, 64'h7, 64'h8, 64'h99, 5'b11111, 1'b1,
          3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 0);

    // Flush in IDLE suppresses acceptance
    req_valid = 1'b1; req_func7 = 7'b0000001; req_func3 = 3'b000; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    check("idle_flush_no_wb", 64'(wb_valid), 64'(0));

    // CSR writes: clear wins over write, then plain write, then clear
    fflags_wr = 1'b1; fflags_wdata = 5'h15; fflags_clr = 1'b1;
    @(posedge clk); #1;
    check("clr_beats_wr", 64'(fflags), 64'(0));
    fflags_clr = 1'b0;
    @(posedge clk); #1;
    fflags_wr = 1'b0;
    check("fflags_write", 64'(fflags), 64'(5'h15));
    fflags_clr = 1'b1; @(posedge clk); #1; fflags_clr = 1'b0;
    check("fflags_clr2", 64'(fflags), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator side of the combinational FPU datapath interface (func7/func3/rs2, operand_a/b in; result_out and five flags out).
- Accepts one decoded F/D instruction at a time from the pipeline.
- Resolves the dynamic rounding mode, NaN-unboxes single-precision operands, drives registered operands to the FPU and waits LATENCY cycles.
- Captures result and flags, formats the result for writeback, and accumulates sticky fflags for the CSR file.

Parameters:
LATENCY, 1, cycles from FPU input registers valid to result capture (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  instruction request valid
req_ready  out  1  block can accept a request
req_func7  in  7  FPU opcode
req_func3  in  3  rounding mode / compare predicate (111 = dynamic)
req_rs2  in  5  convert subtype (bit0 = unsigned)
req_rd  in  5  destination register index
req_op_a  in  64  operand A
req_op_b  in  64  operand B
flush  in  1  abort in-flight operation
frm  in  3  CSR dynamic rounding mode
fpu_func7  out  7  to FPU
fpu_func3  out  3  to FPU, resolved rounding mode
fpu_rs2  out  5  to FPU
fpu_operand_a  out  64  to FPU
fpu_operand_b  out  64  to FPU
fpu_result  in  64  from FPU
fpu_flags  in  5  from FPU {invalid, divbyzero, overflow, underflow, inexact}
wb_valid  out  1  writeback valid
wb_ready  in  1  writeback accepted
wb_rd  out  5  destination index
wb_data  out  64  formatted result
wb_is_int  out  1  result targets integer regfile
wb_illegal  out  1  instruction rejected, no FPU op performed
fflags  out  5  sticky accrued flags {NV,DZ,OF,UF,NX}
fflags_wr  in  1  CSR write of fflags
fflags_wdata  in  5  CSR write data
fflags_clr  in  1  CSR clear of fflags

Behaviour:
- Reset: state IDLE; req_ready=1. wb_valid, wb_illegal, wb_is_int = 0. wb_data, wb_rd, all fpu_* outputs = 0. fflags = 0.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: req_ready=1. On req_valid, decode.
  - Legal request: register fpu_* outputs and go to EXEC.
  - Illegal request: go to RESP with wb_illegal=1, wb_data=0, fpu_* unchanged.
  - EXEC: counter runs 0..LATENCY-1. fpu_* held stable. On the final count, capture fpu_result/fpu_flags into wb_data/flag register and go to RESP.
  - RESP: wb_valid=1. All wb_* held until wb_ready. On handshake go to IDLE.
- Latency: wb_valid rises LATENCY+1 cycles after the accepting edge. req_ready=0 outside IDLE. Throughput is one op per LATENCY+2 cycles.
- Legal func7 set: FADD/FSUB/FMUL/FDIV .S/.D (0000000, 0000001, 0000100, 0000101, 0001000, 0001001, 0001100, 0001101); FCMP_S/D (1010000/1010001); FCVT (0100000, 0100001, 1100000, 1100001, 1101000, 1101001). Any other func7 is illegal.
- Rounding resolution (non-compare ops):
  - func3=111 substitutes frm.
  - func3 in {101,110} is illegal.
  - Substituted frm in {101,110,111} is illegal.
- Compare ops: func3 passed through unchanged; legal only for 000, 001, 010.
- NaN-unboxing: for .S ops (func7[0]=0, except FCVT_S_D, FCVT_S_W, FCVT_W_D), an FP operand whose bits[63:32] != 0xFFFFFFFF is replaced by 0x00000000_7FC00000. Integer-source converts (1101xxx) are never unboxed.
- Result formatting:
  - FCMP and FCVT_W_* set wb_is_int=1. FCMP writes result unchanged. FCVT_W_* writes {32{result[31]}, result[31:0]}.
  - Single-precision FP results are NaN-boxed: {32'hFFFFFFFF, result[31:0]}.
  - Double-precision results are passed unchanged.
- fflags:
  - On the RESP handshake of a legal op, fflags |= captured flags.
  - fflags_clr -> 0.
  - fflags_wr -> fflags_wdata.
  - Same cycle: fflags_clr beats fflags_wr; an accumulate on the same edge is ORed into the written/cleared value.
  - Illegal ops never update fflags.
- flush:
  - In EXEC or RESP: next state IDLE, wb_valid deasserts next cycle, captured flags discarded.
  - In IDLE: suppresses acceptance that cycle.
  - rst has priority over everything.
- Simultaneous RESP handshake and req_valid: the request is not accepted until IDLE (next cycle).

Decomposition:
- fpu_pkg holds:
  - func7 opcode localparams
  - FP32/FP64/INT32/UINT32 codes
  - fflags bit indices
  - FSM state enum
  - canonical NaN constants: 0x7FC00000; 0x7FF8000000000000
- One sub-module, fpu_issue_decode (combinational): legality check, rounding resolution, unbox selection, wb_is_int/format select.

Test Plan:
- FADD.S, func3=111, frm=000, a=0xFFFFFFFF_3F800000, b=0xFFFFFFFF_40000000, LATENCY=1 -> fpu_func3=000; wb_valid 2 cycles after accept; wb_data=0xFFFFFFFF_40400000; fflags=0.
- FMUL.S, a=0x00000000_3F800000, b=0xFFFFFFFF_3F800000 -> fpu_operand_a=0x00000000_7FC00000; wb_data=0xFFFFFFFF_7FC00000.
- FCVT.W.S (1100000, rs2=0), a=0xFFFFFFFF_BF800000 -> wb_is_int=1; wb_data=0xFFFFFFFF_FFFFFFFF.
- FDIV.D 0x3FF0000000000000 / 0 -> wb_data=0x7FF0000000000000; fflags=0x08. Follow with exact FADD.D -> fflags stays 0x08. Pulse fflags_clr -> 0x00.
- Hold wb_ready=0 for 5 cycles -> wb_valid/wb_data stable, req_ready=0. Separately, flush during EXEC -> no wb_valid, fflags unchanged, req_ready=1 next cycle.
- FADD.D, func3=111, frm=101 -> wb_valid with wb_illegal=1 one cycle after accept; fpu_* unchanged; fflags unchanged. Separately, func7=0111111 -> same illegal response.
